// File: rtl/row_serializer.sv
// Parallel-to-serial row writer: captures one IM_SIZE-word row and writes it oldest-first to RAM.
// Optional frame checksum accumulator enabled by defining ROW_SER_CHKSUM_EN.
//
// state | meaning
// IDLE  | waiting for a row; row_ready follows en
// SEND  | streaming captured words to RAM, one per enabled cycle
// DONE  | one-cycle frame_done pulse after the last row of a frame
module row_serializer #(
    parameter int BW      = 16,
    parameter int IM_SIZE = 28,
    parameter int AW      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  frame_clr,
    input  logic                  row_valid,
    output logic                  row_ready,
    input  logic [BW*IM_SIZE-1:0] row_data,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_addr,
    output logic [BW-1:0]         ram_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [BW+AW-1:0]      chksum
);

    localparam int RW = BW * IM_SIZE;
    localparam int CW = (IM_SIZE > 1) ? $clog2(IM_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(IM_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   row_cnt_q, row_cnt_d;
    logic [CW-1:0]   word_cnt_q, word_cnt_d;
    logic [RW-1:0]   shadow_q, shadow_d;
    logic            ram_we_q, ram_we_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [BW-1:0]   ram_data_q, ram_data_d;
    logic            frame_done_q, frame_done_d;

    // The shadow register shifts toward its top word, so the oldest sample is always on top.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        row_cnt_d    = row_cnt_q;
        word_cnt_d   = word_cnt_q;
        shadow_d     = shadow_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        frame_done_d = 1'b0;

        if (frame_clr) begin
            state_d    = IDLE;
            addr_d     = '0;
            row_cnt_d  = '0;
            word_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (row_valid && en) begin
                        shadow_d   = row_data;
                        word_cnt_d = '0;
                        state_d    = SEND;
                    end
                end
                SEND: begin
                    if (en) begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = addr_q;
                        ram_data_d = shadow_q[RW-1 -: BW];
                        shadow_d   = shadow_q << BW;
                        addr_d     = addr_q + AW'(1);
                        word_cnt_d = word_cnt_q + CW'(1);
                        if (word_cnt_q == LAST) begin
                            word_cnt_d = '0;
                            if (row_cnt_q == LAST) begin
                                row_cnt_d    = '0;
                                addr_d       = '0;
                                frame_done_d = 1'b1;
                                state_d      = DONE;
                            end else begin
                                row_cnt_d = row_cnt_q + CW'(1);
                                state_d   = IDLE;
                            end
                        end
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            row_cnt_q    <= '0;
            word_cnt_q   <= '0;
            shadow_q     <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            row_cnt_q    <= row_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shadow_q     <= shadow_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Gated by rst so every output reads 0 while reset is held.
    assign row_ready  = ~rst & (state_q == IDLE) & en & ~frame_clr;
    assign busy       = (state_q == SEND);
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign frame_done = frame_done_q;

`ifdef ROW_SER_CHKSUM_EN
    logic [BW+AW-1:0] chksum_q, chksum_d;
    logic             clr_pend_q, clr_pend_d;

    // The finished sum stays visible after frame_done; it is dropped on the next frame's first write.
    always_comb begin
        chksum_d   = chksum_q;
        clr_pend_d = clr_pend_q;
        if (frame_clr) begin
            chksum_d   = '0;
            clr_pend_d = 1'b0;
        end else begin
            if (ram_we_d) begin
                chksum_d   = (clr_pend_q ? '0 : chksum_q) + {{AW{1'b0}}, ram_data_d};
                clr_pend_d = 1'b0;
            end
            if (frame_done_d)
                clr_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chksum_q   <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            chksum_q   <= chksum_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    assign chksum = chksum_q;
`else
    assign chksum = '0;
`endif

endmodule

// File: tb/tb_row_serializer.sv
// Self-checking bench for row_serializer: queue-based reference model plus directed frame scenarios.
module tb_row_serializer;

    localparam int BW = 16;
    localparam int IM = 28;
    localparam int AW = 10;
    localparam int RW = BW * IM;
`ifdef ROW_SER_CHKSUM_EN
    localparam longint FULL_SUM = 64'd51379440;
`else
    localparam longint FULL_SUM = 64'd0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              frame_clr = 1'b0;
    logic              row_valid = 1'b0;
    logic [RW-1:0]     row_data = '0;
    logic              row_ready;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [BW-1:0]     ram_data;
    logic              busy;
    logic              frame_done;
    logic [BW+AW-1:0]  chksum;

    row_serializer #(.BW(BW), .IM_SIZE(IM), .AW(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .frame_clr(frame_clr),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .busy(busy), .frame_done(frame_done), .chksum(chksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending words in send order, linear frame address, row count.
    int     m_q[$];
    bit     m_send, m_done, m_pend;
    int     m_addr, m_rows;
    longint m_chk;
    bit     e_we, e_fd;
    int     e_addr, e_data;
    int     fd_seen, we_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint exp_chk();
`ifdef ROW_SER_CHKSUM_EN
        return m_chk;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_send = 0; m_done = 0; m_pend = 0;
        m_addr = 0; m_rows = 0; m_chk = 0;
        e_we = 0; e_fd = 0; e_addr = 0; e_data = 0;
    endtask

    task automatic step(input logic en_i, input logic clr_i, input logic val_i,
                        input logic [RW-1:0] data_i);
        int w;
        en = en_i; frame_clr = clr_i; row_valid = val_i; row_data = data_i;
        #1;
        check("row_ready", row_ready, (!m_send && !m_done && en_i && !clr_i));
        check("busy", busy, m_send);
        e_we = 0; e_fd = 0;
        if (clr_i) begin
            m_q.delete();
            m_send = 0; m_done = 0; m_addr = 0; m_rows = 0; m_chk = 0; m_pend = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_send) begin
            if (en_i) begin
                w = m_q.pop_front();
                e_we = 1; e_addr = m_addr; e_data = w;
                if (m_pend) begin m_chk = 0; m_pend = 0; end
                m_chk += w;
                m_addr++;
                if (m_q.size() == 0) begin
                    m_send = 0;
                    m_rows++;
                    if (m_rows == IM) begin
                        m_rows = 0; m_addr = 0; m_done = 1; e_fd = 1; m_pend = 1;
                    end
                end
            end
        end else if (val_i && en_i) begin
            for (int k = IM - 1; k >= 0; k--) m_q.push_back(int'(data_i[k*BW +: BW]));
            m_send = 1;
        end
        @(posedge clk);
        #1;
        check("ram_we", ram_we, e_we);
        check("ram_addr", ram_addr, e_addr);
        check("ram_data", ram_data, e_data);
        check("frame_done", frame_done, e_fd);
        check("chksum", chksum, exp_chk());
        if (ram_we) we_seen++;
        if (frame_done) fd_seen++;
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int k = 0; k < IM; k++) r[k*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, ram_we, 0);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_data"}, ram_data, 0);
        check({tag, "_fd"}, frame_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, row_ready, 0);
        check({tag, "_chksum"}, chksum, 0);
    endtask

    initial begin
        logic [RW-1:0] r;
        logic [RW-1:0] ones;
        model_reset();
        fd_seen = 0; we_seen = 0;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Single row of 100+k, en held high.
        for (int k = 0; k < IM; k++) r[k*BW +: BW] = BW'(100 + k);
        we_seen = 0;
        step(1, 0, 1, r);
        for (int i = 0; i < 32; i++) step(1, 0, 0, r);
        check("row_we_cycles", we_seen, IM);

        // Stall for 3 cycles after the fifth word.
        r = rand_row();
        step(1, 0, 1, r);
        for (int i = 0; i < 5; i++) step(1, 0, 0, r);
        for (int i = 0; i < 3; i++) step(0, 0, 0, r);
        we_seen = 0;
        for (int i = 0; i < 26; i++) step(1, 0, 0, r);
        check("stall_rest_writes", we_seen, IM - 5);

        // Async reset in the middle of a row.
        r = rand_row();
        step(1, 0, 1, r);
        for (int i = 0; i < 10; i++) step(1, 0, 0, r);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1, 0, 0, r);

        // Restart, abort row 3 at word 10 with row_valid high, then a full frame of 16'hFFFF.
        step(1, 1, 0, r);
        for (int i = 0; i < 3 * (IM + 1) + 11; i++) begin
            if (i % (IM + 1) == 0) r = rand_row();
            step(1, 0, 1, r);
        end
        step(1, 1, 1, r);
        ones = '1;
        fd_seen = 0;
        for (int i = 0; i < IM * (IM + 1) + 4; i++) begin
            step(1, 0, 1, ones);
            if (frame_done) begin
                check("frame_last_addr", ram_addr, IM * IM - 1);
                check("frame_chksum", chksum, FULL_SUM);
            end
        end
        check("frame_done_count", fd_seen, 1);

        // Randomized traffic.
        r = rand_row();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) r = rand_row();
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 249) == 0),
                 ($urandom_range(0, 3) != 0), r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
